// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-outstanding AXI memory responder with fixed
// 8-byte beats over an internal word array. FIXED and INCR bursts are
// always supported; WRAP bursts are honoured only when AXI_MEM_WRAP_EN is
// defined, otherwise they complete as SLVERR bursts with writes suppressed.
module axi_mem_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned IW = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

`ifdef AXI_MEM_WRAP_EN
  localparam bit WRAP_SUPPORTED = 1'b1;
`else
  localparam bit WRAP_SUPPORTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, R_BURST, W_DATA, W_RESP} state_t;

  // Bursts flagged here still run their full beat count but answer SLVERR.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    logic len_ok;
    logic e;
    len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      BURST_FIXED, BURST_INCR: e = 1'b0;
      BURST_WRAP:              e = !(WRAP_SUPPORTED && len_ok);
      default:                 e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx,
                                             input logic [1:0]    burst,
                                             input logic [7:0]    len);
    logic [IW-1:0] mask;
    logic [IW-1:0] inc;
    logic [IW-1:0] n;
    mask = IW'(len);
    inc  = idx + IW'(1);
    case (burst)
      BURST_INCR: n = inc;
      BURST_WRAP: n = (idx & ~mask) | (inc & mask);
      default:    n = idx;
    endcase
    return n;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  werr_q, werr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  awready, arready, wready;
  logic                  mem_we;
  logic                  last_mism;
  logic [IW-1:0]         aw_idx, ar_idx, nidx;
  logic                  aw_err, ar_err;

  // Offset bits [2:0] and address bits above the array are aliased away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:IW+3], s_axi_awaddr[2:0],
                              s_axi_araddr[ADDR_WIDTH-1:IW+3], s_axi_araddr[2:0]};

  assign aw_idx = s_axi_awaddr[IW+2:3];
  assign ar_idx = s_axi_araddr[IW+2:3];
  assign aw_err = burst_err(s_axi_awburst, s_axi_awlen);
  assign ar_err = burst_err(s_axi_arburst, s_axi_arlen);
  assign nidx   = next_idx(idx_q, burst_q, len_q);

  assign s_axi_awready = awready && !reset;
  assign s_axi_arready = arready && !reset;
  assign s_axi_wready  = wready && !reset;
  assign s_axi_bvalid  = (state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (state_q == R_BURST);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

  // Next-state, burst bookkeeping and handshake outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    burst_d   = burst_q;
    err_d     = err_q;
    werr_d    = werr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    bresp_d   = bresp_q;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    mem_we    = 1'b0;
    last_mism = s_axi_wlast != (cnt_q == 8'd0);
    case (state_q)
      IDLE: begin
        awready = 1'b1;
        arready = !s_axi_awvalid;
        if (s_axi_awvalid) begin
          state_d = W_DATA;
          idx_d   = aw_idx;
          cnt_d   = s_axi_awlen;
          len_d   = s_axi_awlen;
          burst_d = s_axi_awburst;
          err_d   = aw_err;
          werr_d  = 1'b0;
        end else if (s_axi_arvalid) begin
          state_d = R_BURST;
          idx_d   = ar_idx;
          cnt_d   = s_axi_arlen;
          len_d   = s_axi_arlen;
          burst_d = s_axi_arburst;
          err_d   = ar_err;
          rdata_d = ar_err ? '0 : mem_q[ar_idx];
          rresp_d = ar_err ? RESP_SLVERR : RESP_OKAY;
          rlast_d = (s_axi_arlen == 8'd0);
        end
      end
      R_BURST: begin
        if (s_axi_rready) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
            rlast_d = 1'b0;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            idx_d   = nidx;
            rdata_d = err_q ? '0 : mem_q[nidx];
            rlast_d = (cnt_q == 8'd1);
          end
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we = !err_q;
          if (last_mism) werr_d = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = W_RESP;
            bresp_d = (err_q || werr_q || last_mism) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
            idx_d = nidx;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      werr_q  <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
      bresp_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      werr_q  <= werr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
      bresp_q <= bresp_d;
    end
  end

  // Backing store: full-word writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[idx_q] <= s_axi_wdata;
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a table of read bursts against a
// preloaded region plus hand sequences for arbitration, stalls, WLAST
// errors and reset abandonment.
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [63:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  axi_mem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

`ifdef AXI_MEM_WRAP_EN
  localparam logic [1:0] WRAP_RESP = 2'b00;
`else
  localparam logic [1:0] WRAP_RESP = 2'b10;
`endif

  typedef struct {
    logic [63:0]     addr;
    logic [7:0]      len;
    logic [1:0]      burst;
    logic [1:0]      resp;
    logic [7:0][9:0] idx;
  } rvec_t;

  rvec_t tbl[11];

  function automatic logic [63:0] pat(input int i);
    return 64'hD000_0000_0000_0000 | 64'(i);
  endfunction

  function automatic rvec_t mk(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                               input logic [1:0] r, input int i0 = 0, input int i1 = 0,
                               input int i2 = 0, input int i3 = 0, input int i4 = 0,
                               input int i5 = 0, input int i6 = 0, input int i7 = 0);
    rvec_t v;
    v.addr = a; v.len = l; v.burst = b; v.resp = r;
    v.idx[0] = 10'(i0); v.idx[1] = 10'(i1); v.idx[2] = 10'(i2); v.idx[3] = 10'(i3);
    v.idx[4] = 10'(i4); v.idx[5] = 10'(i5); v.idx[6] = 10'(i6); v.idx[7] = 10'(i7);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // All transfer tasks start and end at posedge+1.
  task automatic aw_send(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b);
    logic ok = 1'b0;
    s_axi_awaddr = a; s_axi_awlen = l; s_axi_awburst = b; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = s_axi_awready;
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0;
    check("aw_handshake", ok, 1);
  endtask

  task automatic ar_send(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b);
    logic ok = 1'b0;
    s_axi_araddr = a; s_axi_arlen = l; s_axi_arburst = b; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = s_axi_arready;
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
    check("ar_handshake", ok, 1);
    @(negedge clk);
    check("r_first_beat_latency", s_axi_rvalid, 1);
    @(posedge clk); #1;
  endtask

  task automatic w_send(input logic [63:0] d, input logic last);
    logic ok = 1'b0;
    s_axi_wdata = d; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = s_axi_wready;
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("w_handshake", ok, 1);
  endtask

  task automatic b_recv(input string name, input logic [1:0] exp_resp);
    logic ok = 1'b0;
    logic [1:0] resp = '0;
    s_axi_bready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = s_axi_bvalid; resp = s_axi_bresp;
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b0;
    check({name, "_bvalid"}, ok, 1);
    check({name, "_bresp"}, resp, exp_resp);
  endtask

  task automatic r_recv(input string name, input logic [63:0] d, input logic [1:0] r,
                        input logic last);
    logic ok = 1'b0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = s_axi_rvalid;
      if (ok) begin
        check({name, "_rdata"}, s_axi_rdata, d);
        check({name, "_rresp"}, s_axi_rresp, r);
        check({name, "_rlast"}, s_axi_rlast, last);
      end
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b0;
    check({name, "_rvalid"}, ok, 1);
  endtask

  task automatic r_done(input string name);
    @(negedge clk);
    check({name, "_rvalid_after_last"}, s_axi_rvalid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] d;

    tbl[0]  = mk(64'h08, 8'd2, 2'b01, 2'b00, 1, 2, 3);
    tbl[1]  = mk(64'h28, 8'd2, 2'b00, 2'b00, 5, 5, 5);
    tbl[2]  = mk(64'h68, 8'd7, 2'b10, WRAP_RESP, 13, 14, 15, 8, 9, 10, 11, 12);
    tbl[3]  = mk(64'h18, 8'd3, 2'b10, WRAP_RESP, 3, 0, 1, 2);
    tbl[4]  = mk(64'h2C, 8'd1, 2'b10, WRAP_RESP, 5, 4);
    tbl[5]  = mk(64'h00, 8'd2, 2'b10, 2'b10);
    tbl[6]  = mk(64'h10, 8'd1, 2'b11, 2'b10);
    tbl[7]  = mk(64'hFFFF_0000_0000_2010, 8'd0, 2'b01, 2'b00, 2);
    tbl[8]  = mk(64'h1FF8, 8'd1, 2'b01, 2'b00, 1023, 0);
    tbl[9]  = mk(64'h78, 8'd2, 2'b01, 2'b00, 15, 16, 17);
    tbl[10] = mk(64'h00, 8'd0, 2'b01, 2'b00, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", s_axi_awready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_bresp", s_axi_bresp, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_awready", s_axi_awready, 1);
    check("idle_arready", s_axi_arready, 1);
    @(posedge clk); #1;

    // INCR write then read back at 0x40
    aw_send(64'h40, 8'd3, 2'b01);
    for (int b = 0; b < 4; b++) w_send(64'hA0 + 64'(b), b == 3);
    b_recv("incr_wr", 2'b00);
    ar_send(64'h40, 8'd3, 2'b01);
    for (int b = 0; b < 4; b++)
      r_recv($sformatf("incr_rd_b%0d", b), 64'hA0 + 64'(b), 2'b00, b == 3);
    r_done("incr_rd");

    // Simultaneous AW/AR: write wins, read sees new data
    s_axi_awaddr = 64'h40; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
    s_axi_araddr = 64'h40; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("arb_awready", s_axi_awready, 1);
    check("arb_arready", s_axi_arready, 0);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    @(negedge clk);
    check("arb_arready_in_wdata", s_axi_arready, 0);
    @(posedge clk); #1;
    w_send(64'h55, 1'b1);
    b_recv("arb_wr", 2'b00);
    ar_send(64'h40, 8'd0, 2'b01);
    r_recv("arb_rd", 64'h55, 2'b00, 1'b1);
    r_done("arb_rd");

    // Early WLAST: all four beats still taken, SLVERR
    aw_send(64'h100, 8'd3, 2'b01);
    for (int b = 0; b < 4; b++) w_send(64'hE0 + 64'(b), b == 1);
    b_recv("early_wlast", 2'b10);
    // Missing WLAST on final beat
    aw_send(64'h120, 8'd1, 2'b01);
    w_send(64'hE8, 1'b0);
    w_send(64'hE9, 1'b0);
    b_recv("missing_wlast", 2'b10);

    // Preload words 0..31 and 1023
    aw_send(64'h0, 8'd31, 2'b01);
    for (int b = 0; b < 32; b++) w_send(pat(b), b == 31);
    b_recv("preload", 2'b00);
    aw_send(64'h1FF8, 8'd0, 2'b01);
    w_send(pat(1023), 1'b1);
    b_recv("preload_top", 2'b00);

    // Reserved burst write must not touch memory
    aw_send(64'h0, 8'd1, 2'b11);
    w_send(64'hBAD, 1'b0);
    w_send(64'hBAD, 1'b1);
    b_recv("rsvd_wr", 2'b10);

    // Read burst table
    for (int k = 0; k < 11; k++) begin
      ar_send(tbl[k].addr, tbl[k].len, tbl[k].burst);
      for (int b = 0; b <= int'(tbl[k].len); b++) begin
        d = (tbl[k].resp == 2'b00) ? pat(int'(tbl[k].idx[b])) : 64'h0;
        r_recv($sformatf("tbl%0d_b%0d", k, b), d, tbl[k].resp, b == int'(tbl[k].len));
      end
      r_done($sformatf("tbl%0d", k));
    end

    // RREADY stall mid-burst and on the last beat
    ar_send(64'h0, 8'd3, 2'b01);
    r_recv("stall_b0", pat(0), 2'b00, 1'b0);
    r_recv("stall_b1", pat(1), 2'b00, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_mid_rvalid", s_axi_rvalid, 1);
      check("stall_mid_rdata", s_axi_rdata, pat(2));
      check("stall_mid_rlast", s_axi_rlast, 0);
      @(posedge clk); #1;
    end
    r_recv("stall_b2", pat(2), 2'b00, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall_last_rdata", s_axi_rdata, pat(3));
      check("stall_last_rlast", s_axi_rlast, 1);
      @(posedge clk); #1;
    end
    r_recv("stall_b3", pat(3), 2'b00, 1'b1);
    r_done("stall");

    // Reset in the middle of a read burst
    ar_send(64'h0, 8'd7, 2'b01);
    r_recv("rrst_b0", pat(0), 2'b00, 1'b0);
    r_recv("rrst_b1", pat(1), 2'b00, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rrst_rvalid", s_axi_rvalid, 0);
    check("rrst_rlast", s_axi_rlast, 0);
    check("rrst_rdata", s_axi_rdata, 0);
    check("rrst_awready", s_axi_awready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    s_axi_rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rrst_no_more_beats", s_axi_rvalid, 0);
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b0;

    // Reset in the middle of a write burst: no B response follows
    aw_send(64'h200, 8'd3, 2'b01);
    w_send(64'h77, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s_axi_bready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wrst_bvalid", s_axi_bvalid, 0);
      check("wrst_wready", s_axi_wready, 0);
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b0;
    ar_send(64'h08, 8'd0, 2'b01);
    r_recv("post_rst_rd", pat(1), 2'b00, 1'b1);
    r_done("post_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Param DATA_WIDTH, 64, beat width in bits; fixed 8-byte beats, no size field.
REQ-002 Param ADDR_WIDTH, 64, AXI address width.
REQ-003 Param MEM_WORDS, 1024, backing-store depth in DATA_WIDTH words; power of two.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address.
REQ-007 s_axi_awlen  in  8  write beats minus one.
REQ-008 s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-009 s_axi_awvalid  in  1  AW request valid.
REQ-010 s_axi_awready  out  1  AW accepted.
REQ-011 s_axi_wdata  in  DATA_WIDTH  write beat data, full-word writes.
REQ-012 s_axi_wlast  in  1  initiator marks final write beat.
REQ-013 s_axi_wvalid  in  1  W beat valid.
REQ-014 s_axi_wready  out  1  W beat accepted.
REQ-015 s_axi_bresp  out  2  write response, 00 OKAY, 10 SLVERR.
REQ-016 s_axi_bvalid  out  1  write response valid.
REQ-017 s_axi_bready  in  1  initiator accepts B.
REQ-018 s_axi_araddr  in  ADDR_WIDTH  read burst start byte address.
REQ-019 s_axi_arlen  in  8  read beats minus one.
REQ-020 s_axi_arburst  in  2  encoding as awburst.
REQ-021 s_axi_arvalid  in  1  AR request valid.
REQ-022 s_axi_arready  out  1  AR accepted.
REQ-023 s_axi_rdata  out  DATA_WIDTH  read beat data.
REQ-024 s_axi_rresp  out  2  per-beat response, 00 OKAY, 10 SLVERR.
REQ-025 s_axi_rlast  out  1  final read beat.
REQ-026 s_axi_rvalid  out  1  read beat valid.
REQ-027 s_axi_rready  in  1  initiator accepts R beat.

Function
REQ-028 FSM states IDLE, R_BURST, W_DATA, W_RESP; one transaction in flight.
REQ-029 IDLE: awready=1; arready=!awvalid; simultaneous AW and AR valid -> AW wins, AR held off.
REQ-030 Word index = addr[clog2(MEM_WORDS)+2:3]; bits [2:0] and upper bits ignored (aliasing).
REQ-031 Beat counter loads len at handshake, decrements per accepted beat; burst ends at count 0.
REQ-032 Next index: FIXED unchanged; INCR +1 modulo MEM_WORDS; WRAP with mask=len keeps index&~mask, advances (index+1)&mask.
REQ-033 WRAP with len not in {1,3,7,15}, or burst 11 -> every beat SLVERR, rdata 0, writes suppressed, beat count still honoured.
REQ-034 R_BURST: rvalid=1 starting the cycle after AR handshake; rdata/rresp/rlast registered, stable while rvalid && !rready.
REQ-035 rlast=1 exactly on beat len+1; its handshake -> IDLE, rvalid=0 next cycle.
REQ-036 W_DATA: wready=1; each handshake writes wdata to current index that edge.
REQ-037 wlast on a non-final beat, or missing on final beat -> bresp SLVERR; burst length still set by awlen.
REQ-038 Final W handshake -> W_RESP; bvalid=1 held until bready; then IDLE.
REQ-039 Write visible to any read whose AR handshake follows the B handshake.

Reset
REQ-040 Reset: state IDLE, all valid/ready/last outputs 0, data/resp outputs 0; memory contents not cleared; reset mid-burst abandons it without B or further R beats.

Configuration
REQ-041 AXI_MEM_WRAP_EN defined: WRAP bursts per REQ-032; undefined: all WRAP bursts handled as REQ-033 error bursts.

Verification
REQ-042 INCR write awaddr=0x40, awlen=3, data 0xA0..0xA3 -> bresp 00; INCR read same -> 0xA0..0xA3, rlast beat 4 only.
REQ-043 WRAP read araddr=0x68, arlen=7 (WRAP_EN) -> indices 13,14,15,8,9,10,11,12, rresp 00.
REQ-044 AWVALID and ARVALID same cycle in IDLE -> awready=1, arready=0; read served after B handshake, returns new data.
REQ-045 rready low 3 cycles mid-burst -> rdata/rlast unchanged, no beat skipped or repeated.
REQ-046 awlen=3, wlast asserted on beat 2 -> 4 beats accepted, bresp 10; burst 11 read len=1 -> 2 beats rresp 10, rdata 0.
